// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use interlock, control-flush and freeze controller for the 5-stage RV32I pipeline
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      ir_d,
    input  logic [31:0]      ir_e,
    input  logic             br_taken_e,
    input  logic             mem_busy,
    input  logic             done,
    input  logic             clr_stats,
    output logic [3:0]       en,
    output logic [2:0]       flush,
    output logic             lu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int   REM_W  = $clog2(LOAD_LAT + 1);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic             r_state;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [6:0] w_op_d;
    logic [6:0] w_op_e;
    logic [4:0] w_rd_e;
    logic [4:0] w_rs1_d;
    logic [4:0] w_rs2_d;
    logic       w_use1;
    logic       w_use2;
    logic       w_hz;
    logic       w_freeze;
    logic       w_stall;
    logic       w_flush_ev;
    logic       w_unused;

    assign w_op_d  = ir_d[6:0];
    assign w_op_e  = ir_e[6:0];
    assign w_rd_e  = ir_e[11:7];
    assign w_rs1_d = ir_d[19:15];
    assign w_rs2_d = ir_d[24:20];

    // LUI, AUIPC and JAL carry immediate bits in the rs fields, so they never match
    assign w_use1 = w_op_d inside {7'b0010011, 7'b0000011, 7'b1100111,
                                   7'b0110011, 7'b0100011, 7'b1100011};
    assign w_use2 = w_op_d inside {7'b0110011, 7'b0100011, 7'b1100011};

    assign w_hz = (w_op_e == 7'b0000011) && (w_rd_e != 5'd0) &&
                  ((w_use1 && (w_rd_e == w_rs1_d)) || (w_use2 && (w_rd_e == w_rs2_d)));

    assign w_freeze   = mem_busy || !done;
    assign w_flush_ev = !w_freeze && br_taken_e;
    assign w_stall    = !w_freeze && !br_taken_e &&
                        ((w_hz && (r_state == S_IDLE)) || (r_state == S_WAIT));

    assign w_unused = ^{ir_d[31:25], ir_d[14:7], ir_e[31:12]};

    always_comb begin
        en    = 4'b0000;
        flush = 3'b000;
        if (rstn && !w_freeze) begin
            if (br_taken_e) begin
                en    = 4'b1111;
                flush = 3'b110;
            end else if (w_stall) begin
                en    = 4'b1001;
                flush = 3'b010;
            end else begin
                en    = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else if (!w_freeze) begin
            if (br_taken_e) begin
                r_state <= S_IDLE;
                r_rem   <= '0;
            end else if (r_state == S_IDLE) begin
                if (w_hz && (LOAD_LAT > 1)) begin
                    r_state <= S_WAIT;
                    r_rem   <= REM_W'(LOAD_LAT - 1);
                end
            end else begin
                r_rem <= r_rem - REM_W'(1);
                if (r_rem == REM_W'(1)) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!w_freeze) begin
            if (clr_stats) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign lu_busy   = (r_state == S_WAIT);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule
